pio_bank: RTL
=============

PIO_BANK -- requirements
Module: pio_bank

Interface
REQ-001 Parameter DATA_W, default 8, PIO width in bits; legal range 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 0, input stability window in clocks; 0 bypasses debounce.
REQ-003 Parameter OUT_RESET, default 0, reset value of the output register (DATA_W bits).
REQ-004 Port: clk_clk, input, 1 bit, sole clock; all logic rising-edge.
REQ-005 Port: reset_reset_n, input, 1 bit, asynchronous active-low reset.
REQ-006 Port: avs_address, input, 3 bits, word address of the register.
REQ-007 Port: avs_read, input, 1 bit, read strobe.
REQ-008 Port: avs_write, input, 1 bit, write strobe.
REQ-009 Port: avs_writedata, input, 32 bits, write data; bits above DATA_W are ignored.
REQ-010 Port: avs_readdata, output, 32 bits, read data; bits above DATA_W read 0.
REQ-011 Port: pio_in, input, DATA_W bits, asynchronous external inputs.
REQ-012 Port: pio_out, output, DATA_W bits, registered outputs.
REQ-013 Port: irq, output, 1 bit, level interrupt, high while any (EDGE_CAP & IRQ_MASK) bit is 1.

Function
REQ-014 Register map: 0 DATA (R: debounced input; W: load OUT); 1 OUT_SET (W1S); 2 OUT_CLR (W1C); 3 IRQ_MASK (RW); 4 EDGE_CAP (R; W1C); 5 RISE_EN (RW); 6 FALL_EN (RW); 7 OUT readback (R).
REQ-015 Writes to read-only addresses and reads of write-only addresses (1, 2) have no effect and return 0.
REQ-016 Read latency is fixed at 1 cycle: avs_readdata is valid the cycle after avs_read and holds until the next read.
REQ-017 pio_in passes through a 2-flop synchroniser per bit before any other use.
REQ-018 With DEBOUNCE_CYCLES=N>0, each bit has a counter that reloads on any synchronised change; the debounced value updates only after N consecutive stable cycles.
REQ-019 Pulses shorter than N cycles never reach the debounced value.
REQ-020 Edge detect compares debounced value against its 1-cycle delayed copy; a rise sets EDGE_CAP[i] if RISE_EN[i]=1, a fall sets it if FALL_EN[i]=1.
REQ-021 An edge and a W1C of the same EDGE_CAP bit in the same cycle: set wins.
REQ-022 OUT_SET and OUT_CLR update pio_out one cycle after the write; a DATA write likewise.
REQ-023 irq asserts one cycle after EDGE_CAP/IRQ_MASK satisfy REQ-013 and deasserts one cycle after the condition clears.
REQ-024 Input latency: pio_in change to DATA readback = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles; edge capture follows one cycle later.
REQ-025 Simultaneous avs_read and avs_write: both execute; read returns the pre-write value.

Reset
REQ-026 On reset_reset_n low: pio_out=OUT_RESET, IRQ_MASK=0, EDGE_CAP=0, RISE_EN=0, FALL_EN=0, avs_readdata=0, irq=0, synchronisers/debounced/delayed copies=0, debounce counters=0.
REQ-027 Reset asserted mid-debounce or mid-transaction discards all state; first post-release input change does not register a spurious edge from the reset-zero baseline until it reaches the debounced value.
REQ-028 Reset deassertion is synchronised externally; the block makes no provision for it.

Structure
REQ-029 Register address constants (ADDR_DATA..ADDR_OUT_RB) reside in a shared package pio_bank_pkg.
REQ-030 Per-bit synchroniser plus debounce counter is one sub-module pio_debounce, instantiated DATA_W times via generate.
REQ-031 Debounce counter width is $clog2(DEBOUNCE_CYCLES+1), minimum 1.

Verification
REQ-032 Reset, then read addr 7 -> 0x00 (OUT_RESET=0); write 0xA5 to addr 0, read 7 -> 0xA5; write 0x0F to addr 1 -> pio_out 0xAF; write 0x03 to addr 2 -> 0xAC.
REQ-033 DEBOUNCE_CYCLES=4: pio_in[0] 3-cycle pulse -> DATA bit 0 stays 0, EDGE_CAP 0; 10-cycle pulse -> DATA bit 0 =1 at cycle 7 after change.
REQ-034 RISE_EN=0x01, IRQ_MASK=0x01, pio_in[0] 0->1 -> EDGE_CAP=0x01, irq=1; W1C 0x01 to addr 4 -> irq=0 next cycle.
REQ-035 FALL_EN=0x80 only; pio_in[7] 1->0 -> EDGE_CAP=0x80; 0->1 -> no change.
REQ-036 Edge on bit 2 in the same cycle as W1C 0x04 -> EDGE_CAP bit 2 remains 1.
REQ-037 Assert reset while debounce counter at 2 of 4 -> all outputs per REQ-026, no edge captured after release.

Source files
------------

// File: rtl/pio_bank_pkg.sv
// Shared constants, bus payload type and helpers for the PIO bank.
package pio_bank_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned BUS_W  = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_OUT_SET  = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_OUT_CLR  = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_OUT_RB   = 3'd7;

  // One slave-side bus command as seen in a single cycle.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              wr;
    logic [BUS_W-1:0]  wdata;
  } avs_cmd_t;

  // Stability counter width: must hold the value n, never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pio_bank_if.sv
// Avalon-MM style register port of the PIO bank.
interface pio_bank_if;
  import pio_bank_pkg::*;

  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [BUS_W-1:0]  avs_writedata;
  logic [BUS_W-1:0]  avs_readdata;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/pio_debounce.sv
// One PIO input bit: 2-flop synchroniser followed by an optional stability filter.
module pio_debounce
  import pio_bank_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic s1;
  logic s2;

  // Two-stage synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    // No filtering: debounced value is simply the synchronised value, one flop later.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout <= 1'b0;
      else        dout <= s2;
    end
  end else begin : g_filter
    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] cnt;

    // Count cycles the synchronised value disagrees with the output; any return
    // to agreement restarts the window, so short pulses never pass.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt  <= '0;
        dout <= 1'b0;
      end else if (s2 == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
        dout <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pio_bank.sv
// Parallel I/O bank: output register with set/clear, debounced inputs, edge capture and IRQ.
module pio_bank
  import pio_bank_pkg::*;
#(
  parameter int unsigned      DATA_W          = 8,
  parameter int unsigned      DEBOUNCE_CYCLES = 0,
  parameter logic [DATA_W-1:0] OUT_RESET      = '0
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  pio_bank_if.slave         avs,
  input  logic [DATA_W-1:0] pio_in,
  output logic [DATA_W-1:0] pio_out,
  output logic              irq
);

  avs_cmd_t          cmd_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] w1c_c;
  logic [DATA_W-1:0] rise_c;
  logic [DATA_W-1:0] fall_c;
  logic [BUS_W-1:0]  rd_mux_c;

  logic [DATA_W-1:0] db;
  logic [DATA_W-1:0] db_d;
  logic [DATA_W-1:0] out_q;
  logic [DATA_W-1:0] irq_mask;
  logic [DATA_W-1:0] edge_cap;
  logic [DATA_W-1:0] rise_en;
  logic [DATA_W-1:0] fall_en;
  logic [BUS_W-1:0]  rdata_q;
  logic              irq_q;

  assign cmd_c = '{addr: avs.avs_address, rd: avs.avs_read, wr: avs.avs_write,
                   wdata: avs.avs_writedata};
  assign wdata_c = cmd_c.wdata[DATA_W-1:0];

  if (DATA_W < BUS_W) begin : g_wd_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^cmd_c.wdata[BUS_W-1:DATA_W];
  end

  // Per-bit synchroniser and debounce filter.
  for (genvar i = 0; i < int'(DATA_W); i++) begin : g_bit
    pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .din   (pio_in[i]),
      .dout  (db[i])
    );
  end

  // Delayed copy of the debounced inputs for edge detection.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) db_d <= '0;
    else                db_d <= db;
  end

  assign rise_c = db & ~db_d;
  assign fall_c = ~db & db_d;

  // Write-one-to-clear request for EDGE_CAP.
  always_comb begin
    w1c_c = '0;
    if (cmd_c.wr && (cmd_c.addr == ADDR_EDGE_CAP)) w1c_c = wdata_c;
  end

  // Edge capture: a new enabled edge overrides a same-cycle clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) edge_cap <= '0;
    else edge_cap <= (edge_cap & ~w1c_c) | (rise_c & rise_en) | (fall_c & fall_en);
  end

  // Writable control registers and the output latch.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_q    <= OUT_RESET;
      irq_mask <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
    end else if (cmd_c.wr) begin
      case (cmd_c.addr)
        ADDR_DATA:     out_q    <= wdata_c;
        ADDR_OUT_SET:  out_q    <= out_q | wdata_c;
        ADDR_OUT_CLR:  out_q    <= out_q & ~wdata_c;
        ADDR_IRQ_MASK: irq_mask <= wdata_c;
        ADDR_RISE_EN:  rise_en  <= wdata_c;
        ADDR_FALL_EN:  fall_en  <= wdata_c;
        default: ;
      endcase
    end
  end

  // Level interrupt, one cycle behind the captured-and-masked state.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) irq_q <= 1'b0;
    else                irq_q <= |(edge_cap & irq_mask);
  end

  // Read mux over the current (pre-write) register values.
  always_comb begin
    rd_mux_c = '0;
    case (cmd_c.addr)
      ADDR_DATA:     rd_mux_c = BUS_W'(db);
      ADDR_IRQ_MASK: rd_mux_c = BUS_W'(irq_mask);
      ADDR_EDGE_CAP: rd_mux_c = BUS_W'(edge_cap);
      ADDR_RISE_EN:  rd_mux_c = BUS_W'(rise_en);
      ADDR_FALL_EN:  rd_mux_c = BUS_W'(fall_en);
      ADDR_OUT_RB:   rd_mux_c = BUS_W'(out_q);
      default:       rd_mux_c = '0;
    endcase
  end

  // Read data register: loads on a read strobe, holds otherwise.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)  rdata_q <= '0;
    else if (cmd_c.rd)   rdata_q <= rd_mux_c;
  end

  assign avs.avs_readdata = rdata_q;
  assign pio_out          = out_q;
  assign irq              = irq_q;

endmodule
